ram_wr_arbiter: RTL and testbench

Write-side controller for the 8x32 dual-port RAM in the asynchronous FIFO. It shares the RAM write port between two requesters using round-robin arbitration. It generates the write address sequence and tracks slot occupancy from credits returned by the read side. It runs entirely in the write clock domain and drives the RAM's write enable, write address and write data directly.

---
 rtl/ram_arb_pkg.sv | 9 +
 rtl/ram_wr_arbiter_if.sv | 32 +++
 rtl/ram_wr_arbiter_rr_arb2.sv | 32 +++
 rtl/ram_wr_arbiter.sv | 109 ++++++++++
 tb/tb_ram_wr_arbiter.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the FIFO write-side RAM arbiter.
package ram_arb_pkg;
    localparam int DW_DEF = 32;
    localparam int AW_DEF = 3;
    localparam int REQ0   = 0;
    localparam int REQ1   = 1;

    typedef enum logic [1:0] {RUN, DRAIN, CLR} state_e;
endpackage

// File: rtl/ram_wr_arbiter_if.sv
// Requester, credit, flush and RAM-write-port bundle of the write arbiter.
interface ram_wr_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
);
    logic [1:0]    req_vld;
    logic [DW-1:0] req_data0;
    logic [DW-1:0] req_data1;
    logic [1:0]    req_rdy;
    logic          crd_ret;
    logic          flush;
    logic          flush_done;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [AW:0]   occ;
    logic          full;
    logic          empty;
    logic          crd_err;

    modport master (
        output req_vld, req_data0, req_data1, crd_ret, flush,
        input  req_rdy, flush_done, ram_we, ram_addr, ram_din, occ, full, empty, crd_err
    );

    modport slave (
        input  req_vld, req_data0, req_data1, crd_ret, flush,
        output req_rdy, flush_done, ram_we, ram_addr, ram_din, occ, full, empty, crd_err
    );
endinterface

// File: rtl/ram_wr_arbiter_rr_arb2.sv
// Two-way grant select. RAM_ARB_FIXED_PRIO_EN makes requester 0 win every tie
// and removes the last_grant register; otherwise ties alternate round-robin.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] vld_i,
    input  logic       acc_i,
    output logic       gnt_o
);
`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_ok;
    assign unused_ok = &{clk_i, rst_i, acc_i};
    assign gnt_o     = (vld_i == 2'b10);
`else
    logic last_q, last_d;

    // With no or both requesters valid, prefer the one that did not win last.
    always_comb begin
        unique case (vld_i)
            2'b01:   gnt_o = 1'b0;
            2'b10:   gnt_o = 1'b1;
            default: gnt_o = ~last_q;
        endcase
        last_d = acc_i ? gnt_o : last_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) last_q <= 1'b1;
        else       last_q <= last_d;
    end
`endif
endmodule

// File: rtl/ram_wr_arbiter.sv
// Write-domain controller for the async FIFO RAM: arbitrates two requesters,
// generates write addresses and tracks occupancy from returned credits.
module ram_wr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
)(
    input logic              wclk,
    input logic              wrst,
    ram_wr_arbiter_if.slave  bus
);
    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    state_e        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic          we_q, we_d;
    logic [AW:0]   occ_q, occ_d;
    logic          err_q, err_d;
    logic          gnt, open, accept, full;
    logic [1:0]    rdy;

    rr_arb2 u_arb (
        .clk_i (wclk),
        .rst_i (wrst),
        .vld_i (bus.req_vld),
        .acc_i (accept),
        .gnt_o (gnt)
    );

    assign full = (occ_q == DEPTH);

    // Ready is gated by wrst so nothing handshakes while reset is held.
    always_comb begin
        open      = (state_q == RUN) & ~full & ~bus.flush & ~wrst;
        rdy       = '0;
        rdy[REQ0] = open & ~gnt;
        rdy[REQ1] = open & gnt;
        accept    = |(rdy & bus.req_vld);
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        addr_d  = addr_q;
        din_d   = din_q;
        we_d    = 1'b0;
        occ_d   = occ_q;
        err_d   = err_q;
        unique case (state_q)
            RUN: begin
                if (bus.flush) state_d = DRAIN;
                if (accept) begin
                    we_d   = 1'b1;
                    addr_d = wptr_q;
                    din_d  = rdy[REQ1] ? bus.req_data1 : bus.req_data0;
                    wptr_d = wptr_q + AW'(1);
                end
                unique case ({accept, bus.crd_ret})
                    2'b10: occ_d = occ_q + (AW+1)'(1);
                    2'b01: begin
                        if (occ_q == '0) err_d = 1'b1;
                        else             occ_d = occ_q - (AW+1)'(1);
                    end
                    default: ;
                endcase
            end
            DRAIN: state_d = CLR;
            CLR: begin
                state_d = RUN;
                wptr_d  = '0;
                occ_d   = '0;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q <= RUN;
            wptr_q  <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            occ_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            we_q    <= we_d;
            occ_q   <= occ_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_rdy    = rdy;
    assign bus.flush_done = (state_q == CLR);
    assign bus.ram_we     = we_q;
    assign bus.ram_addr   = addr_q;
    assign bus.ram_din    = din_q;
    assign bus.occ        = occ_q;
    assign bus.full       = full;
    assign bus.empty      = (occ_q == '0);
    assign bus.crd_err    = err_q;
endmodule

// File: tb/tb_ram_wr_arbiter.sv
// Scoreboarded random + directed bench for ram_wr_arbiter.
module tb_ram_wr_arbiter;
    import ram_arb_pkg::*;
    localparam int DW = 32;
    localparam int AW = 3;

    logic wclk = 1'b0;
    logic wrst;
    always #5 wclk = ~wclk;

    ram_wr_arbiter_if #(.DW(DW), .AW(AW)) bus();
    ram_wr_arbiter #(.DW(DW), .AW(AW)) dut (.wclk(wclk), .wrst(wrst), .bus(bus));

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    wr_t sbq[$];

    int pass_n = 0, tot_n = 0;

    // Reference model: occupancy count, next slot, tie preference, flush phase.
    int m_occ, m_wp, m_phase, m_last, m_err, last_acc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic m_reset();
        m_occ = 0; m_wp = 0; m_phase = 0; m_last = 1; m_err = 0; last_acc = -1;
        sbq.delete();
    endtask

    always @(negedge wclk) begin
        if (!wrst && bus.ram_we) begin
            if (sbq.size() == 0) chk("sb_underflow", sbq.size(), 1);
            else begin
                wr_t e;
                e = sbq.pop_front();
                chk("ram_addr", bus.ram_addr, e.a);
                chk("ram_din", bus.ram_din, e.d);
            end
        end
    end

    task automatic model_step(input logic [1:0] v, input logic [DW-1:0] a, b, input logic c, f);
        int win;
        logic [1:0] exp_hs;
        wr_t e;
        chk("occ", bus.occ, m_occ);
        chk("full", bus.full, m_occ == 8);
        chk("empty", bus.empty, m_occ == 0);
        chk("crd_err", bus.crd_err, m_err);
        chk("flush_done", bus.flush_done, m_phase == 2);
        win = -1;
        if (m_phase == 0 && m_occ < 8 && !f) begin
            if (v == 2'b01)      win = 0;
            else if (v == 2'b10) win = 1;
            else if (v == 2'b11) win = (m_last == 1) ? 0 : 1;
        end
        exp_hs = (win < 0) ? 2'b00 : 2'(1 << win);
        chk("handshake", bus.req_rdy & v, exp_hs);
        last_acc = win;
        case (m_phase)
            0: begin
                if (win >= 0) begin
                    e.a = AW'(m_wp);
                    e.d = (win == 1) ? b : a;
                    sbq.push_back(e);
                    m_wp = (m_wp + 1) % 8;
                    m_last = win;
                end
                if (win >= 0 && !c) m_occ++;
                else if (win < 0 && c) begin
                    if (m_occ == 0) m_err = 1;
                    else m_occ--;
                end
                if (f) m_phase = 1;
            end
            1: m_phase = 2;
            default: begin m_phase = 0; m_occ = 0; m_wp = 0; end
        endcase
    endtask

    task automatic cyc(input logic [1:0] v, input logic [DW-1:0] a, b, input logic c, f);
        bus.req_vld = v; bus.req_data0 = a; bus.req_data1 = b;
        bus.crd_ret = c; bus.flush = f;
        @(negedge wclk);
        model_step(v, a, b, c, f);
        @(posedge wclk); #1;
    endtask

    logic p0, p1;
    logic [DW-1:0] d0, d1;

    initial begin
        wrst = 1'b1;
        bus.req_vld = 2'b11; bus.req_data0 = '0; bus.req_data1 = '0;
        bus.crd_ret = 1'b0; bus.flush = 1'b0;
        #12;
        chk("rst_rdy", bus.req_rdy, 0);
        chk("rst_we", bus.ram_we, 0);
        chk("rst_addr", bus.ram_addr, 0);
        chk("rst_din", bus.ram_din, 0);
        chk("rst_occ", bus.occ, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_err", bus.crd_err, 0);
        chk("rst_fdone", bus.flush_done, 0);
        @(posedge wclk); #1;
        wrst = 1'b0;
        m_reset();

        // Both held valid: 0x11 first, then alternating, until full.
        for (int k = 0; k < 8; k++) cyc(2'b11, 32'h11, 32'h22, 1'b0, 1'b0);
        chk("full_rdy", bus.req_rdy, 0);
        chk("full_occ", bus.occ, 8);

        cyc(2'b00, '0, '0, 1'b0, 1'b1);
        cyc(2'b00, '0, '0, 1'b0, 1'b0);
        cyc(2'b00, '0, '0, 1'b0, 1'b0);
        chk("flush_empty", bus.empty, 1);

        for (int k = 0; k < 8; k++) cyc(2'b01, 32'hA0 + k, '0, 1'b0, 1'b0);
        chk("a_full", bus.full, 1);
        chk("a_rdy", bus.req_rdy, 0);
        cyc(2'b01, 32'hA8, '0, 1'b0, 1'b0);

        cyc(2'b00, '0, '0, 1'b1, 1'b0);
        chk("crd_occ7", bus.occ, 7);
        chk("crd_notfull", bus.full, 0);
        cyc(2'b01, 32'hB0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cyc(2'b00, '0, '0, 1'b1, 1'b0);
        cyc(2'b10, '0, 32'h33, 1'b1, 1'b0);
        chk("simul_occ5", bus.occ, 5);

        // Reset right after an accept: the in-flight write must vanish at once.
        cyc(2'b01, 32'hC0, '0, 1'b0, 1'b0);
        wrst = 1'b1;
        #1;
        chk("async_we", bus.ram_we, 0);
        chk("async_occ", bus.occ, 0);
        m_reset();
        @(posedge wclk); #1;
        wrst = 1'b0;

        for (int k = 0; k < 4; k++) cyc(2'b11, 32'h40 + k, 32'h50 + k, 1'b0, 1'b0);
        cyc(2'b00, '0, '0, 1'b0, 1'b1);
        cyc(2'b00, '0, '0, 1'b0, 1'b0);
        cyc(2'b00, '0, '0, 1'b0, 1'b0);
        chk("f4_occ", bus.occ, 0);
        cyc(2'b10, '0, 32'h77, 1'b0, 1'b0);

        cyc(2'b00, '0, '0, 1'b1, 1'b0);
        cyc(2'b00, '0, '0, 1'b1, 1'b0);
        chk("err_set", bus.crd_err, 1);
        chk("err_occ", bus.occ, 0);

        p0 = 1'b0; p1 = 1'b0; d0 = '0; d1 = '0;
        for (int n = 0; n < 400; n++) begin
            if (!p0 && $urandom_range(1, 0) == 1) begin p0 = 1'b1; d0 = $urandom; end
            if (!p1 && $urandom_range(1, 0) == 1) begin p1 = 1'b1; d1 = $urandom; end
            cyc({p1, p0}, d0, d1, ($urandom % 3) == 0, ($urandom % 25) == 0);
            if (last_acc == 0) p0 = 1'b0;
            if (last_acc == 1) p1 = 1'b0;
        end
        cyc(2'b00, '0, '0, 1'b0, 1'b0);
        cyc(2'b00, '0, '0, 1'b0, 1'b0);
        chk("err_sticky", bus.crd_err, 1);
        chk("sb_drained", sbq.size(), 0);

        wrst = 1'b1;
        #1;
        chk("err_clr", bus.crd_err, 0);
        m_reset();
        @(posedge wclk); #1;
        wrst = 1'b0;

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
